// File: rtl/msk_aes_mc_serial_pkg.sv
// ============================================================================
// Module   : msk_aes_mc_serial_pkg
// Brief    : FSM encoding, column width and GF(2^8) MixColumns coefficients.
// Revision : 1.0
// ============================================================================
`default_nettype none

package msk_aes_mc_serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    localparam int c_col_w = 32;

    // Row 0 of each circulant matrix; row r is this row rotated right by r.
    localparam logic [3:0][7:0] c_fwd_coef = {8'h01, 8'h01, 8'h03, 8'h02};
    localparam logic [3:0][7:0] c_inv_coef = {8'h09, 8'h0d, 8'h0b, 8'h0e};

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] coef);
        logic [7:0] res;
        logic [7:0] acc;
        res = 8'h00;
        acc = a;
        for (int i = 0; i < 8; i++) begin
            if (coef[i]) res = res ^ acc;
            acc = gf_xtime(acc);
        end
        return res;
    endfunction

    // Linear in a, so applying it to each share separately preserves the masking.
    function automatic logic [3:0][7:0] mix_col(input logic [3:0][7:0] a,
                                                input logic [3:0][7:0] coef);
        logic [3:0][7:0] res;
        logic [1:0]      idx;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                idx    = 2'(k - r);
                res[r] = res[r] ^ gf_mul(a[k], coef[idx]);
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/msk_aes_mc_serial_col.sv
// ============================================================================
// Module   : msk_aes_mc_col
// Brief    : Combinational sharewise (Inv)MixColumns on one masked column.
// Revision : 1.0
// ============================================================================
`default_nettype none

module msk_aes_mc_col
    import msk_aes_mc_serial_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [c_col_w*d-1:0] col_in,
    input  logic                 mode,
    output logic [c_col_w*d-1:0] col_out
);

    for (genvar i = 0; i < d; i++) begin : g_share
        logic [3:0][7:0] w_sh_in;
        logic [3:0][7:0] w_fwd;
        logic [3:0][7:0] w_inv;
        logic [3:0][7:0] w_sh_out;

        for (genvar k = 0; k < 4; k++) begin : g_byte
            for (genvar j = 0; j < 8; j++) begin : g_bit
                assign w_sh_in[k][j]               = col_in[8*d*k + d*j + i];
                assign col_out[8*d*k + d*j + i]    = w_sh_out[k][j];
            end
        end

        assign w_fwd    = mix_col(w_sh_in, c_fwd_coef);
        assign w_inv    = mix_col(w_sh_in, c_inv_coef);
        assign w_sh_out = mode ? w_inv : w_fwd;
    end

endmodule

`default_nettype wire

// File: rtl/msk_aes_mc_serial.sv
// ============================================================================
// Module   : msk_aes_mc_serial
// Brief    : Masked AES (Inv)MixColumns, one column per cycle, valid/ready I/O.
// Revision : 1.0
// ============================================================================
`default_nettype none

module msk_aes_mc_serial
    import msk_aes_mc_serial_pkg::*;
#(
    parameter int d    = 2,
    parameter int NCOL = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_inverse,
    input  logic [c_col_w*d*NCOL-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [c_col_w*d*NCOL-1:0] out_data
);

    localparam int c_colw  = c_col_w * d;
    localparam int c_dataw = c_colw * NCOL;
    localparam int c_cntw  = (NCOL > 1) ? $clog2(NCOL) : 1;

    mc_state_e           r_state;
    logic [c_cntw-1:0]   r_cnt;
    logic                r_mode;
    logic [c_dataw-1:0]  r_data;
    logic [c_colw-1:0]   w_col_in;
    logic [c_colw-1:0]   w_col_out;

    always_comb begin
        w_col_in = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (r_cnt == c_cntw'(c)) w_col_in = r_data[c*c_colw +: c_colw];
        end
    end

    msk_aes_mc_col #(
        .d (d)
    ) u_col (
        .col_in  (w_col_in),
        .mode    (r_mode),
        .col_out (w_col_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_mode  <= in_inverse;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int c = 0; c < NCOL; c++) begin
                        if (r_cnt == c_cntw'(c)) r_data[c*c_colw +: c_colw] <= w_col_out;
                    end
                    if (r_cnt == c_cntw'(NCOL - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        // Accepting here gives back-to-back operation without a bubble.
                        if (in_valid) begin
                            r_data  <= in_data;
                            r_mode  <= in_inverse;
                            r_cnt   <= '0;
                            r_state <= ST_BUSY;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_msk_aes_mc_serial.sv
// ============================================================================
// Module   : tb_msk_aes_mc_serial
// Brief    : Randomized self-checking bench with a behavioural reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_msk_aes_mc_serial;

    localparam int D    = 2;
    localparam int NCOL = 4;
    localparam int W    = 32 * D * NCOL;

    typedef logic [3:0][7:0]           col_t;
    typedef logic [NCOL-1:0][3:0][7:0] st_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_inverse = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic rand_ordy = 1'b0;
    int ov_cycles[$];

    msk_aes_mc_serial #(.d(D), .NCOL(NCOL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inverse (in_inverse),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic col_t mc_col(input col_t a, input logic inv);
        logic [7:0] cf[4];
        col_t r;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int row = 0; row < 4; row++)
            for (int k = 0; k < 4; k++)
                r[row] = r[row] ^ gmul(cf[(k - row + 4) % 4], a[k]);
        return r;
    endfunction

    function automatic st_t mc_state(input st_t s, input logic inv);
        st_t r;
        for (int c = 0; c < NCOL; c++) r[c] = mc_col(s[c], inv);
        return r;
    endfunction

    function automatic col_t col_of(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [8*D-1:0] mask_byte(input logic [7:0] b);
        logic [8*D-1:0] s;
        logic x;
        s = '0;
        for (int j = 0; j < 8; j++) begin
            x = b[j];
            for (int i = 0; i < D - 1; i++) begin
                s[D*j + i] = 1'($urandom);
                x = x ^ s[D*j + i];
            end
            s[D*j + D - 1] = x;
        end
        return s;
    endfunction

    function automatic logic [7:0] unmask_byte(input logic [8*D-1:0] s);
        logic [7:0] b;
        b = '0;
        for (int j = 0; j < 8; j++)
            for (int i = 0; i < D; i++) b[j] = b[j] ^ s[D*j + i];
        return b;
    endfunction

    function automatic logic [W-1:0] mask_state(input st_t s);
        logic [W-1:0] r;
        for (int c = 0; c < NCOL; c++)
            for (int k = 0; k < 4; k++)
                r[32*D*c + 8*D*k +: 8*D] = mask_byte(s[c][k]);
        return r;
    endfunction

    function automatic st_t unmask_state(input logic [W-1:0] v);
        st_t r;
        for (int c = 0; c < NCOL; c++)
            for (int k = 0; k < 4; k++)
                r[c][k] = unmask_byte(v[32*D*c + 8*D*k +: 8*D]);
        return r;
    endfunction

    function automatic st_t rand_state();
        st_t r;
        for (int c = 0; c < NCOL; c++)
            for (int k = 0; k < 4; k++) r[c][k] = 8'($urandom);
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- timing/result model ----------------
    // m_busy counts remaining processing cycles; m_have marks a result on offer.
    int   m_busy = 0;
    logic m_have = 1'b0;
    st_t  m_exp  = '0;

    function automatic logic exp_rdy();
        return (!m_have && m_busy == 0) || (m_have && out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 0;
            m_have <= 1'b0;
        end else begin
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) m_have <= 1'b1;
            end else if (m_have && out_ready) begin
                m_have <= 1'b0;
            end
            if (exp_rdy() && in_valid) begin
                m_busy <= NCOL;
                m_have <= 1'b0;
                m_exp  <= mc_state(unmask_state(in_data), in_inverse);
            end
        end
    end

    logic         prev_ov = 1'b0;
    logic         prev_or = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", W'(in_ready), W'(exp_rdy()));
            check("out_valid", W'(out_valid), W'(m_have));
            if (m_have && out_valid) check("out_data", W'(unmask_state(out_data)), W'(m_exp));
            if (prev_ov && !prev_or && out_valid) check("hold", out_data, prev_data);
            if (out_valid) ov_cycles.push_back(cyc);
        end
        prev_ov   <= out_valid;
        prev_or   <= out_ready;
        prev_data <= out_data;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ordy) out_ready = 1'($urandom);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input st_t s, input logic mode, output int acc);
        bit ok;
        ok         = 1'b0;
        acc        = 0;
        in_data    = mask_state(s);
        in_inverse = mode;
        in_valid   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no in_ready, expected in_ready=1");
        end
        @(posedge clk);
        #1;
        acc        = cyc;
        in_valid   = 1'b0;
        in_inverse = ~mode;
        in_data    = {8{$urandom}};
    endtask

    task automatic wait_out(output int oc);
        oc = -1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid) begin
                oc = cyc;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL out_timeout: got no out_valid, expected out_valid=1");
    endtask

    task automatic run_dir(input string name, input st_t s, input logic mode,
                           input col_t exp0, output logic [W-1:0] raw);
        int a, o;
        st_t u;
        send(s, mode, a);
        wait_out(o);
        check({name, "_latency"}, W'(o - a), W'(NCOL));
        u   = unmask_state(out_data);
        raw = out_data;
        check({name, "_col0"}, W'(u[0]), W'(exp0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        st_t s;
        logic [W-1:0] raw1, raw2;
        st_t u1, u2;
        int a, o, nov;

        // model pins
        check("model_fwd", W'(mc_col(col_of(8'hdb, 8'h13, 8'h53, 8'h45), 1'b0)),
              W'(col_of(8'h8e, 8'h4d, 8'ha1, 8'hbc)));
        check("model_inv", W'(mc_col(col_of(8'h8e, 8'h4d, 8'ha1, 8'hbc), 1'b1)),
              W'(col_of(8'hdb, 8'h13, 8'h53, 8'h45)));
        check("model_fwd2", W'(mc_col(col_of(8'hf2, 8'h0a, 8'h22, 8'h5c), 1'b0)),
              W'(col_of(8'h9f, 8'hdc, 8'h58, 8'h9d)));

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;

        // directed vectors
        s = rand_state(); s[0] = col_of(8'hdb, 8'h13, 8'h53, 8'h45);
        run_dir("fwd_db", s, 1'b0, col_of(8'h8e, 8'h4d, 8'ha1, 8'hbc), raw1);
        s = rand_state(); s[0] = col_of(8'h8e, 8'h4d, 8'ha1, 8'hbc);
        run_dir("inv_8e", s, 1'b1, col_of(8'hdb, 8'h13, 8'h53, 8'h45), raw1);
        s = rand_state(); s[0] = col_of(8'hf2, 8'h0a, 8'h22, 8'h5c);
        run_dir("fwd_f2", s, 1'b0, col_of(8'h9f, 8'hdc, 8'h58, 8'h9d), raw1);
        s = rand_state(); s[0] = col_of(8'h01, 8'h01, 8'h01, 8'h01);
        run_dir("inv_01", s, 1'b1, col_of(8'h01, 8'h01, 8'h01, 8'h01), raw1);
        run_dir("fwd_01a", s, 1'b0, col_of(8'h01, 8'h01, 8'h01, 8'h01), raw1);
        run_dir("fwd_01b", s, 1'b0, col_of(8'h01, 8'h01, 8'h01, 8'h01), raw2);
        u1 = unmask_state(raw1);
        u2 = unmask_state(raw2);
        check("remask_same_value", W'(u2), W'(u1));
        n_tests++;
        if (raw1 === raw2) begin
            n_fail++;
            $display("FAIL remask_shares: got identical shares %h, expected different", raw2);
        end

        // back-to-back
        repeat (3) @(posedge clk);
        #1;
        ov_cycles.delete();
        for (int k = 0; k < 3; k++) begin
            in_data    = mask_state(rand_state());
            in_inverse = 1'($urandom);
            in_valid   = 1'b1;
            for (int t = 0; t < 50; t++) begin
                @(negedge clk);
                if (in_ready) break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("b2b_count", W'(ov_cycles.size()), W'(3));
        if (ov_cycles.size() == 3) begin
            check("b2b_period1", W'(ov_cycles[1] - ov_cycles[0]), W'(NCOL + 1));
            check("b2b_period2", W'(ov_cycles[2] - ov_cycles[1]), W'(NCOL + 1));
        end

        // backpressure
        out_ready = 1'b0;
        send(rand_state(), 1'($urandom), a);
        wait_out(o);
        raw1 = out_data;
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            check("bp_valid", W'(out_valid), W'(1));
            check("bp_ready", W'(in_ready), W'(0));
            check("bp_data", out_data, raw1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // reset mid-BUSY at cnt=2
        send(rand_state(), 1'b0, a);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_out_data", out_data, '0);
        @(posedge clk);
        #3 rst = 1'b0;
        nov = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (out_valid) nov++;
        end
        check("abort_no_out", W'(nov), W'(0));

        // randomized traffic
        rand_ordy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(rand_state(), 1'($urandom), a);
        end
        rand_ordy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
